// File: rtl/btn_pkg.sv
// Shared definitions for the button event slice: channel state encoding and default sizing.
// N_BTN_DEF is shared with the debouncer so both sides agree on channel count.
package btn_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPress = 2'd1,
        StHeld  = 2'd2
    } btn_state_e;

    localparam int unsigned N_BTN_DEF        = 5;
    localparam int unsigned LONG_TICKS_DEF   = 1000;
    localparam int unsigned REPEAT_TICKS_DEF = 200;
    localparam int unsigned CNT_W_DEF        = 10;

endpackage

// File: rtl/btn_event_ch.sv
// One button channel: edge detect, press/long/held/repeat FSM and tick counter.
// Auto-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_event_ch
    import btn_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = LONG_TICKS_DEF,
    parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_db_i,
    output logic btn_press_o,
    output logic btn_release_o,
    output logic btn_long_o,
    output logic btn_held_o,
    output logic btn_repeat_o
);

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);

    btn_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             prev_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             held_q;
    logic             repeat_q;
    logic             rise;
    logic             fall;

    assign rise = btn_db_i & ~prev_q;
    assign fall = ~btn_db_i & prev_q;

    // Edges outrank the tick, so a release on the threshold tick never reaches HELD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            prev_q    <= btn_db_i;
            press_q   <= rise;
            release_q <= fall;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            if (fall) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                held_q  <= 1'b0;
            end else if (rise) begin
                state_q <= StPress;
                cnt_q   <= '0;
            end else if (tick_i) begin
                case (state_q)
                    StPress: begin
                        if (cnt_q == LongLast) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                            long_q  <= 1'b1;
                            held_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StHeld: begin
`ifdef BTN_AUTO_REPEAT_EN
                        if (cnt_q == CNT_W'(REPEAT_TICKS - 1)) begin
                            cnt_q    <= '0;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`else
                        cnt_q <= '0;
`endif
                    end
                    default: begin
                        cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;
    assign btn_long_o    = long_q;
    assign btn_held_o    = held_q;
    assign btn_repeat_o  = repeat_q;

endmodule

// File: rtl/btn_event.sv
// Turns debounced button levels into one-clk press/release/long/repeat events plus a held level.
// Define BTN_AUTO_REPEAT_EN to enable auto-repeat pulses while held.
module btn_event
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN        = N_BTN_DEF,
    parameter int unsigned LONG_TICKS   = LONG_TICKS_DEF,
    parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic [N_BTN-1:0] btn_db_i,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [N_BTN-1:0] btn_long_o,
    output logic [N_BTN-1:0] btn_held_o,
    output logic [N_BTN-1:0] btn_repeat_o
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_event_ch #(
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick_i       (tick_i),
            .btn_db_i     (btn_db_i[i]),
            .btn_press_o  (btn_press_o[i]),
            .btn_release_o(btn_release_o[i]),
            .btn_long_o   (btn_long_o[i]),
            .btn_held_o   (btn_held_o[i]),
            .btn_repeat_o (btn_repeat_o[i])
        );
    end

endmodule

// File: doc/btn_event.md
Name: btn_event

Overview:
- Downstream consumer of the 5-channel tick-based debouncer. Turns clean button levels btnDb into discrete UI events:
  - press and release pulses;
  - long-press pulse and held level;
  - optional auto-repeat pulses.
- Outputs feed the buzzer/tone-select control FSM. Each event is one clk wide, so the consumer needs no edge detection.

Parameters:
- N_BTN, 5, number of button channels.
- LONG_TICKS, 1000, ticks of continuous press before long-press (1 s at 1 ms tick).
- REPEAT_TICKS, 200, ticks between auto-repeat pulses while held.
- CNT_W, 10, tick counter width; must hold max(LONG_TICKS, REPEAT_TICKS)-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-clk strobe, 1 ms period; same strobe that drives the debouncer.
- btnDb  input  N_BTN  debounced button levels, 1 = pressed.
- btnPress  output  N_BTN  one-clk pulse per channel on press.
- btnRelease  output  N_BTN  one-clk pulse per channel on release.
- btnLong  output  N_BTN  one-clk pulse when a press reaches LONG_TICKS.
- btnHeld  output  N_BTN  level, high while the channel is in HELD.
- btnRepeat  output  N_BTN  one-clk auto-repeat pulse while HELD.

Behaviour:
- Reset (async): all outputs 0; per-channel prev=0, cnt=0, state=IDLE.
- Channels are fully independent; identical logic per bit.
- prev is sampled every clk, not gated by tick.
  - rise = btnDb & ~prev; fall = ~btnDb & prev.
- Press and release outputs are registered:
  - btnPress = rise; btnRelease = fall.
  - Latency: 1 clk after the btnDb edge; width exactly 1 clk.
- Channel FSM states: IDLE, PRESS, HELD.
  - IDLE: on rise -> PRESS, cnt<=0.
  - PRESS: on tick, cnt<=cnt+1. On tick with cnt==LONG_TICKS-1 -> HELD, cnt<=0, btnLong pulses next clk.
  - HELD: btnHeld=1 (registered, asserted the clk after entry). On tick, cnt counts toward REPEAT_TICKS-1. At the terminal count: cnt<=0, btnRepeat pulses (see optional feature).
  - Any state: fall -> IDLE, cnt<=0, btnHeld<=0.
- Priority, highest first: rst > edge (rise/fall) > tick. A tick coinciding with an edge is ignored for that channel.
- Release in the same clk as the long threshold: release wins; no btnLong, no entry to HELD.
- Short press (released before LONG_TICKS): btnPress, then btnRelease only.
- Counter never exceeds its terminal value; no wrap-around possible.
- btnDb already high when reset deasserts: prev=0, so a btnPress pulse is generated on the first clk. This is the decided behaviour.
- Reset mid-press: all state is cleared.
  - No btnRelease is generated.
  - If still pressed after reset, the event sequence restarts with btnPress.
- Multiple channels may pulse in the same clk; no arbitration.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: HELD emits a btnRepeat pulse every REPEAT_TICKS ticks. The first pulse is REPEAT_TICKS ticks after the btnLong pulse.
- Undefined:
  - btnRepeat is tied to 0.
  - The HELD counter is not clocked; cnt stays 0 in HELD.
  - btnLong and btnHeld behaviour is unchanged.

Decomposition:
- Shared package btn_pkg holds:
  - channel state encoding (IDLE=2'd0, PRESS=2'd1, HELD=2'd2);
  - default LONG_TICKS/REPEAT_TICKS constants;
  - N_BTN, shared with the debouncer.
- Sub-module btn_event_ch: one channel containing prev, FSM, cnt and the 5 output bits.
  - The top instantiates N_BTN copies in a generate loop and concatenates the outputs.

Test Plan (bench: tick every 4 clk, LONG_TICKS=5, REPEAT_TICKS=3, N_BTN=5):
- Reset release with btnDb=0, hold 50 clk -> all outputs 0 throughout.
- btnDb[0] 0->1, held 2 ticks, then 0 -> btnPress[0] 1 clk after rise; btnRelease[0] 1 clk after fall; btnLong/btnHeld/btnRepeat stay 0.
- btnDb[2] held 12 ticks ->
  - btnPress[2];
  - btnLong[2] on the clk after the 5th tick;
  - btnHeld[2]=1 from then until release;
  - with BTN_AUTO_REPEAT_EN: btnRepeat[2] after ticks 8 and 11; without it: btnRepeat=0.
- btnDb[4] falls in the same clk as the 5th tick -> btnRelease[4] pulses, btnLong[4]=0, btnHeld[4]=0.
- btnDb=5'b10101 rises in one clk -> btnPress=5'b10101 in one clk. Then bit 2 releases alone -> btnRelease=5'b00100, other channels keep counting.
- rst asserted while btnDb[1] is HELD, btnDb[1] still 1 -> outputs 0 immediately. After deassert: btnPress[1] pulses, then btnLong[1] 5 ticks later.
